// File: rtl/sub_apb_regbank_if.sv
// APB4 completer-side bus bundle for sub_apb_regbank.
// Signal names match the original flat port list.
interface sub_apb_regbank_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/sub_apb_regbank.sv
// APB4 register bank: NUM_REGS control/status registers, read-only ID at
// index 0, optional wait states, byte strobes, error response, write pulses.
module sub_apb_regbank #(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 0,
  parameter logic [63:0] ID_VALUE    = 64'h0917_0001
) (
  input  logic                           clk,
  input  logic                           rst,
  sub_apb_regbank_if.slave               apb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int          LSB      = $clog2(DATA_WIDTH / 8);
  localparam int          NBYTES   = DATA_WIDTH / 8;
  localparam int unsigned NR       = NUM_REGS;
  localparam logic [DATA_WIDTH-1:0] ID_DATA  = ID_VALUE[DATA_WIDTH-1:0];
  localparam logic [3:0]            CNT_INIT = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;

  logic [31:0]           idx;
  logic                  err;
  logic                  complete;
  logic [DATA_WIDTH-1:0] rd_data;

  // Word index; byte-offset bits below LSB are dropped.
  assign idx = 32'(apb.paddr >> LSB);
  assign err = (idx >= 32'(NUM_REGS)) || (apb.pwrite && idx == 32'd0);

  always_comb begin
    rd_data = '0;
    if (idx == 32'd0) rd_data = ID_DATA;
    for (int unsigned i = 1; i < NR; i++) begin
      if (idx == i) rd_data = regs_q[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          state_d = ACCESS;
          cnt_d   = CNT_INIT;
        end
      end
      ACCESS: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else if (!apb.penable) begin
          // A fresh setup phase restarts the wait count.
          cnt_d = CNT_INIT;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    apb.pready  = complete;
    apb.pslverr = complete && err;
    apb.prdata  = (complete && !apb.pwrite && !err) ? rd_data : '0;
  end

  always_comb begin
    regs_d     = regs_q;
    wr_pulse_d = '0;
    if (complete && apb.pwrite && !err) begin
      for (int unsigned i = 1; i < NR; i++) begin
        if (idx == i) begin
          wr_pulse_d[i] = 1'b1;
          for (int unsigned b = 0; b < NBYTES; b++) begin
            if (apb.pstrb[b]) regs_d[i][b*8 +: 8] = apb.pwdata[b*8 +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_pulse_q <= '0;
      for (int unsigned i = 1; i < NR; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_pulse_q <= wr_pulse_d;
      for (int unsigned i = 1; i < NR; i++) regs_q[i] <= regs_d[i];
    end
  end

  always_comb begin
    reg_out                 = '0;
    reg_out[0 +: DATA_WIDTH] = ID_DATA;
    for (int unsigned i = 1; i < NR; i++) begin
      reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end
  end

  assign wr_pulse = wr_pulse_q;

endmodule

// File: tb/tb_sub_apb_regbank.sv
// Directed bench for sub_apb_regbank: a zero-wait and a three-wait instance
// share one stimulus driver, selected by dsel.
module tb_sub_apb_regbank;

  localparam logic [31:0] ID = 32'h0917_0001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dsel = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;

  logic [511:0] reg_out0, reg_out1;
  logic [15:0]  wr_pulse0, wr_pulse1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_apb_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if0 ();
  sub_apb_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if3 ();

  assign if0.psel = psel & ~dsel;
  assign if3.psel = psel & dsel;
  assign if0.penable = penable;  assign if3.penable = penable;
  assign if0.pwrite  = pwrite;   assign if3.pwrite  = pwrite;
  assign if0.paddr   = paddr;    assign if3.paddr   = paddr;
  assign if0.pwdata  = pwdata;   assign if3.pwdata  = pwdata;
  assign if0.pstrb   = pstrb;    assign if3.pstrb   = pstrb;

  sub_apb_regbank #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16),
                    .WAIT_STATES(0), .ID_VALUE(64'h0917_0001)) dut0 (
    .clk(clk), .rst(rst), .apb(if0), .reg_out(reg_out0), .wr_pulse(wr_pulse0));

  sub_apb_regbank #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16),
                    .WAIT_STATES(3), .ID_VALUE(64'h0917_0001)) dut3 (
    .clk(clk), .rst(rst), .apb(if3), .reg_out(reg_out1), .wr_pulse(wr_pulse1));

  logic        pready_s, pslverr_s;
  logic [31:0] prdata_s;
  logic [15:0] wr_pulse_s;
  assign pready_s   = dsel ? if3.pready  : if0.pready;
  assign pslverr_s  = dsel ? if3.pslverr : if0.pslverr;
  assign prdata_s   = dsel ? if3.prdata  : if0.prdata;
  assign wr_pulse_s = dsel ? wr_pulse1   : wr_pulse0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at #1 after a clock edge, returns at #1 after the completing edge
  // with psel dropped, so a following call is back-to-back.
  task automatic xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output logic er,
                      output int waits, output logic [15:0] pulse);
    logic done;
    done = 1'b0; rd = '0; er = 1'b0; waits = 0; pulse = '0;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1 penable = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pready_s) begin
        rd = prdata_s; er = pslverr_s; done = 1'b1;
        break;
      end
      chk("idle_outputs_during_wait", {pslverr_s, prdata_s}, 33'h0);
      waits++;
      @(posedge clk); #1;
    end
    if (done) begin
      @(posedge clk); #1 pulse = wr_pulse_s;
    end else begin
      checks++; errors++;
      $display("FAIL xfer_timeout: addr %h got no pready required pready within 40 cycles", a);
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [15:0] exp_pulse;
    int          ridx;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          w, w2, c0;
    logic [15:0] pl, pl2;
    logic        seen;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,        4'h0, ID,           1'b0, 16'h0000, 0,  ID};
    vecs[1]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h0,        1'b0, 16'h0000, 1,  32'h0};
    vecs[2]  = '{1'b1, 8'h08, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 16'h0004, 2,  32'hDEADBEEF};
    vecs[3]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 16'h0000, 2,  32'hDEADBEEF};
    vecs[4]  = '{1'b1, 8'h08, 32'h11223344, 4'h5, 32'h0,        1'b0, 16'h0004, 2,  32'hDE22BE44};
    vecs[5]  = '{1'b0, 8'h0A, 32'h0,        4'h0, 32'hDE22BE44, 1'b0, 16'h0000, 2,  32'hDE22BE44};
    vecs[6]  = '{1'b1, 8'h00, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 16'h0000, 0,  ID};
    vecs[7]  = '{1'b1, 8'h40, 32'hAAAAAAAA, 4'hF, 32'h0,        1'b1, 16'h0000, 2,  32'hDE22BE44};
    vecs[8]  = '{1'b0, 8'h40, 32'h0,        4'h0, 32'h0,        1'b1, 16'h0000, 2,  32'hDE22BE44};
    vecs[9]  = '{1'b1, 8'h3C, 32'h12345678, 4'h0, 32'h0,        1'b0, 16'h8000, 15, 32'h0};
    vecs[10] = '{1'b1, 8'h3C, 32'hCAFEF00D, 4'h8, 32'h0,        1'b0, 16'h8000, 15, 32'hCA000000};
    vecs[11] = '{1'b0, 8'h3F, 32'h0,        4'h0, 32'hCA000000, 1'b0, 16'h0000, 15, 32'hCA000000};
    vecs[12] = '{1'b1, 8'hFC, 32'h11111111, 4'hF, 32'h0,        1'b1, 16'h0000, 15, 32'hCA000000};
    vecs[13] = '{1'b1, 8'h04, 32'h00000001, 4'h1, 32'h0,        1'b0, 16'h0002, 1,  32'h00000001};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs_w0", {if0.pready, if0.pslverr, if0.prdata, wr_pulse0}, 50'h0);
    chk("rst_outputs_w3", {if3.pready, if3.pslverr, if3.prdata, wr_pulse1}, 50'h0);
    chk("rst_id_slot", reg_out0[31:0], ID);
    chk("rst_regs_w0", {32'h0, 32'(|reg_out0[511:32])}, 64'h0);
    chk("rst_regs_w3", {32'h0, 32'(|reg_out1[511:32])}, 64'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    dsel = 1'b0;
    for (int i = 0; i < 14; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, w, pl);
      chk($sformatf("v%0d_prdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_pslverr", i), er, vecs[i].exp_err);
      chk($sformatf("v%0d_wr_pulse", i), pl, vecs[i].exp_pulse);
      chk($sformatf("v%0d_reg%0d", i, vecs[i].ridx),
          reg_out0[vecs[i].ridx*32 +: 32], vecs[i].exp_reg);
      chk($sformatf("v%0d_waits", i), w, 0);
    end
    @(posedge clk); #1 chk("pulse_one_cycle", wr_pulse0, 16'h0);

    dsel = 1'b1;
    c0 = cyc;
    xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, er, w, pl);
    chk("w3_id_prdata", rd, ID);
    chk("w3_id_waits", w, 3);
    chk("w3_id_cycles", cyc - c0, 5);

    c0 = cyc;
    xfer(1'b1, 8'h10, 32'h55AA55AA, 4'hF, rd, er, w, pl);
    xfer(1'b0, 8'h10, 32'h0, 4'h0, rd, er, w2, pl2);
    chk("b2b_wr_pulse", pl, 16'h0010);
    chk("b2b_wr_waits", w, 3);
    chk("b2b_rd_waits", w2, 3);
    chk("b2b_rd_prdata", rd, 32'h55AA55AA);
    chk("b2b_total_cycles", cyc - c0, 10);

    // Abort after one wait cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h14; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk); chk("abort_wait_pready", pready_s, 1'b0);
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_pulse", wr_pulse1, 16'h0);
    chk("abort_no_write", reg_out1[5*32 +: 32], 32'h0);
    // Access phase without setup must not complete from IDLE.
    seen = 1'b0;
    psel = 1'b1; penable = 1'b1;
    repeat (6) begin @(negedge clk); seen |= pready_s; end
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    chk("abort_fsm_idle", seen, 1'b0);
    xfer(1'b1, 8'h14, 32'h0BADF00D, 4'hF, rd, er, w, pl);
    chk("post_abort_pulse", pl, 16'h0020);
    chk("post_abort_reg5", reg_out1[5*32 +: 32], 32'h0BADF00D);

    // Reset asserted in the middle of a wait.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h18; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk); rst = 1'b1;
    #1;
    chk("midrst_outputs", {if3.pready, if3.pslverr, wr_pulse1}, 18'h0);
    @(posedge clk); #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    chk("midrst_reg6", reg_out1[6*32 +: 32], 32'h0);
    chk("midrst_reg4_cleared", reg_out1[4*32 +: 32], 32'h0);
    chk("midrst_pulse", wr_pulse1, 16'h0);
    xfer(1'b1, 8'h18, 32'hA5A5A5A5, 4'hF, rd, er, w, pl);
    chk("post_rst_pulse", pl, 16'h0040);
    chk("post_rst_err", er, 1'b0);
    xfer(1'b0, 8'h18, 32'h0, 4'h0, rd, er, w, pl);
    chk("post_rst_readback", rd, 32'hA5A5A5A5);
    chk("post_rst_waits", w, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded required completion before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sub_apb_regbank.md
Name: sub_apb_regbank

Overview:
- Parametrised APB4 completer: bank of NUM_REGS DATA_WIDTH-bit control/status registers for the verification subsystem.
- Adds configurable wait states, byte strobes, error response, read-only ID register and per-register write pulses.
- Sits behind the subsystem bus interface; drives register contents to downstream sub-blocks.

Parameters:
- ADDR_WIDTH, 8: APB address width.
- DATA_WIDTH, 32: data width; a multiple of 8, range 8..64.
- NUM_REGS, 16: number of registers; must be <= 2^(ADDR_WIDTH-LSB), where LSB = log2(DATA_WIDTH/8).
- WAIT_STATES, 0: extra access cycles before pready; range 0..15.
- ID_VALUE, 'h0917_0001: constant returned by register 0, truncated or zero-extended to DATA_WIDTH.

Ports:
- clk  in  1  Single clock; all logic on its rising edge.
- rst  in  1  Asynchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  Byte address.
- pwdata  in  DATA_WIDTH  Write data.
- pstrb  in  DATA_WIDTH/8  Byte-lane write strobes.
- prdata  out  DATA_WIDTH  Read data.
- pready  out  1  Transfer complete.
- pslverr  out  1  Error response, valid only with pready.
- reg_out  out  NUM_REGS*DATA_WIDTH  Flattened register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse  out  NUM_REGS  One-cycle pulse after a successful write to reg i.

Behaviour:
- Reset (async assert, sync deassert by the source):
  - regs 1..NUM_REGS-1 = 0; FSM = IDLE; wait counter = 0.
  - prdata = 0, pready = 0, pslverr = 0, wr_pulse = 0.
  - reg_out slot 0 = ID_VALUE at all times.
- Decode:
  - idx = paddr[ADDR_WIDTH-1:LSB]; paddr[LSB-1:0] ignored.
  - idx >= NUM_REGS -> error.
  - Write to idx 0 -> error.
  - Reads of idx 0 return ID_VALUE.
- FSM states IDLE, ACCESS:
  - IDLE: psel=1, penable=0 (setup) -> ACCESS, cnt <= WAIT_STATES. Any other input -> stay.
  - ACCESS, psel=1, penable=1: if cnt != 0, then cnt <= cnt-1 and pready = 0. If cnt == 0, pready = 1 (combinational) and the transfer completes at that edge -> IDLE.
  - ACCESS with psel=0: abort -> IDLE, no register update, no pulse.
  - ACCESS with psel=1, penable=0: treated as a new setup; reload cnt, stay ACCESS, no update.
- Latency:
  - WAIT_STATES=0: pready in the first access cycle (classic 2-cycle APB transfer).
  - Otherwise the transfer takes 2+WAIT_STATES cycles.
- Outputs:
  - pready = 0 outside the completing cycle.
  - prdata = selected register when pready & !pwrite & !err; otherwise 0. Read of bad idx -> prdata 0, pslverr 1.
  - pslverr = pready & err.
- Write commit (completing edge, !err):
  - byte lane b of reg idx <= pwdata lane b where pstrb[b]=1; other lanes held.
  - wr_pulse[idx] = 1 for the next cycle only, including when pstrb = 0.
  - Error write: no update, no pulse.
- Back-to-back: a setup immediately after completion is accepted from IDLE; no idle cycle is inserted by the block.
- Reset mid-transfer: transfer dropped, no partial write; pready/pslverr low.

Test Plan:
- After reset, read addr 0x00 (WAIT_STATES=0) -> pready in cycle 2, prdata=0x09170001, pslverr=0. Read addr 0x04 -> prdata=0.
- Write 0xDEADBEEF, pstrb=4'b1111 to 0x08 -> reg_out slot 2 = 0xDEADBEEF. wr_pulse=16'h0004 for exactly one cycle. Readback matches.
- Write 0x11223344, pstrb=4'b0101 to 0x08 -> reg 2 = 0xDE22BE44.
- Write to 0x00, and write to 0x40 (idx 16, NUM_REGS=16) -> pslverr=1 with pready. No reg change, wr_pulse=0. Read 0x40 -> prdata=0, pslverr=1.
- WAIT_STATES=3 build: read 0x00 -> pready low for 3 access cycles, high on the 4th. Total 5 cycles. Back-to-back write then read has no gap.
- Drop psel after 1 wait cycle, and separately assert rst mid-access -> FSM IDLE, no write, pready=0. The next normal transfer succeeds.
